// File: rtl/cmp_pkg.sv
// Shared types and constants for the digit-serial word comparator.
// Holds the word FSM states, reset values of the running result, and counter sizing.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic LGN_RST = 1'b0;
  localparam logic EQ_RST  = 1'b1;

  // A single-digit word still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational one-digit magnitude compare with a greater/equal cascade input.
// inv_msb flips both operands' top bit so a two's-complement digit orders as unsigned.
module digit_cmp #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               lgn_in,
  input  logic               e_in,
  input  logic               inv_msb,
  output logic               lgn,
  output logic               e
);

  logic [DIGIT_W-1:0] a_m;
  logic [DIGIT_W-1:0] b_m;

  always_comb begin
    a_m = a;
    b_m = b;
    a_m[DIGIT_W-1] = a[DIGIT_W-1] ^ inv_msb;
    b_m[DIGIT_W-1] = b[DIGIT_W-1] ^ inv_msb;
  end

  // A decided prefix (e_in=0) passes through; otherwise this digit decides.
  assign lgn = lgn_in | (e_in & (a_m > b_m));
  assign e   = e_in & (a_m == b_m);

endmodule

// File: rtl/serial_word_comparator.sv
// Digit-serial A-vs-B magnitude comparator, MSB digit first, with word framing,
// a one-cycle result strobe, signed/unsigned mode, synchronous abort and gap tolerance.
module serial_word_comparator
  import cmp_pkg::*;
#(
  parameter int DIGIT_W    = 1,
  parameter int NUM_DIGITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               signed_mode,
  output logic               lgn_out,
  output logic               e_out,
  output logic               res_valid,
  output logic               busy
);

  localparam int              CNT_W    = cnt_w(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               lgn_reg, lgn_next;
  logic               eq_reg, eq_next;
  logic               rv_reg, rv_next;
  logic               mode_reg, mode_next;

  logic first_digit;
  logic mode_eff;
  logic lgn_in;
  logic e_in;
  logic cmp_lgn;
  logic cmp_e;

  // On the first digit the mode comes straight from the port; later digits use the latched word mode.
  assign first_digit = (state_reg == IDLE);
  assign mode_eff    = first_digit ? signed_mode : mode_reg;
  assign lgn_in      = first_digit ? LGN_RST : lgn_reg;
  assign e_in        = first_digit ? EQ_RST  : eq_reg;

  digit_cmp #(
    .DIGIT_W (DIGIT_W)
  ) u_digit_cmp (
    .a       (a),
    .b       (b),
    .lgn_in  (lgn_in),
    .e_in    (e_in),
    .inv_msb (first_digit & mode_eff),
    .lgn     (cmp_lgn),
    .e       (cmp_e)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      lgn_reg   <= LGN_RST;
      eq_reg    <= EQ_RST;
      rv_reg    <= 1'b0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      lgn_reg   <= lgn_next;
      eq_reg    <= eq_next;
      rv_reg    <= rv_next;
      mode_reg  <= mode_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lgn_next   = lgn_reg;
    eq_next    = eq_reg;
    rv_next    = 1'b0;
    mode_next  = mode_reg;
    if (clear) begin
      state_next = IDLE;
      cnt_next   = '0;
      lgn_next   = LGN_RST;
      eq_next    = EQ_RST;
    end else if (in_valid) begin
      lgn_next = cmp_lgn;
      eq_next  = cmp_e;
      if (first_digit) begin
        mode_next = signed_mode;
      end
      if (cnt_reg == LAST_CNT) begin
        state_next = IDLE;
        cnt_next   = '0;
        rv_next    = 1'b1;
      end else begin
        state_next = RUN;
        cnt_next   = cnt_reg + CNT_W'(1);
      end
    end
  end

  assign lgn_out   = lgn_reg;
  assign e_out     = eq_reg;
  assign res_valid = rv_reg;
  assign busy      = (state_reg == RUN);

endmodule

// File: tb/tb_serial_word_comparator.sv
// Randomised and directed bench for serial_word_comparator (2-bit digits, 4-digit words).
// Expected results come from comparing whole-number prefixes of the operands.
module tb_serial_word_comparator;

  localparam int DW = 2;
  localparam int ND = 4;
  localparam int WW = DW * ND;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          signed_mode = 1'b0;
  logic          lgn_out;
  logic          e_out;
  logic          res_valid;
  logic          busy;

  serial_word_comparator #(
    .DIGIT_W    (DW),
    .NUM_DIGITS (ND)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .lgn_out     (lgn_out),
    .e_out       (e_out),
    .res_valid   (res_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_k;
  int   pa, pb;
  logic word_mode;
  logic exp_lgn, exp_e, exp_rv, exp_busy;

  task automatic check(input string tag, input logic got, input logic expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, expv);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".lgn"}, lgn_out, exp_lgn);
    check({tag, ".e"}, e_out, exp_e);
    check({tag, ".res_valid"}, res_valid, exp_rv);
    check({tag, ".busy"}, busy, exp_busy);
    $display("[TB] %s lgn=%b e=%b rv=%b busy=%b", tag, lgn_out, e_out, res_valid, busy);
  endtask

  task automatic model_reset();
    exp_k     = 0;
    pa        = 0;
    pb        = 0;
    word_mode = 1'b0;
    exp_lgn   = 1'b0;
    exp_e     = 1'b1;
    exp_rv    = 1'b0;
    exp_busy  = 1'b0;
  endtask

  // Accept one digit; the model compares the numeric prefixes received so far.
  task automatic step(input logic [DW-1:0] da, input logic [DW-1:0] db,
                      input logic sm, input string tag);
    int bits, sa, sb;
    a = da; b = db; signed_mode = sm; in_valid = 1'b1; clear = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (exp_k == 0) begin
      word_mode = sm;
      pa = 0;
      pb = 0;
    end
    pa = pa * (1 << DW) + int'(da);
    pb = pb * (1 << DW) + int'(db);
    exp_k++;
    bits = exp_k * DW;
    sa = pa;
    sb = pb;
    if (word_mode) begin
      if (sa >= (1 << (bits - 1))) sa = sa - (1 << bits);
      if (sb >= (1 << (bits - 1))) sb = sb - (1 << bits);
    end
    exp_lgn = (sa > sb);
    exp_e   = (sa == sb);
    if (exp_k == ND) begin
      exp_rv   = 1'b1;
      exp_busy = 1'b0;
      exp_k    = 0;
    end else begin
      exp_rv   = 1'b0;
      exp_busy = 1'b1;
    end
    check_outs(tag);
  endtask

  task automatic gap();
    in_valid = 1'b0; clear = 1'b0;
    a = DW'($urandom); b = DW'($urandom); signed_mode = ($urandom_range(0, 1) != 0);
    @(posedge clk); #1;
    exp_rv = 1'b0;
    check_outs("gap");
  endtask

  task automatic do_clear(input logic with_valid);
    clear = 1'b1; in_valid = with_valid;
    a = DW'($urandom); b = DW'($urandom);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    check_outs("clear");
  endtask

  task automatic send_word(input logic [WW-1:0] wa, input logic [WW-1:0] wb,
                           input logic sm, input int gaps, input string tag);
    logic smd;
    for (int i = ND - 1; i >= 0; i--) begin
      smd = (i == ND - 1) ? sm : ($urandom_range(0, 1) != 0);
      step(wa[i*DW +: DW], wb[i*DW +: DW], smd, tag);
      if (i > 0) repeat (gaps) gap();
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    reset = 1'b1;
    gap();

    // Mid-word asynchronous reset, then a normal word.
    step(2'b10, 2'b01, 1'b0, "pre_rst");
    step(2'b11, 2'b00, 1'b0, "pre_rst");
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    #2 reset = 1'b1;
    gap();
    send_word(8'hC3, 8'h3C, 1'b1, 0, "post_rst");

    send_word(8'hB4, 8'hB1, 1'b0, 0, "b4_b1");
    check("b4_b1.final_lgn", lgn_out, 1'b1);
    check("b4_b1.final_e", e_out, 1'b0);
    gap();

    send_word(8'h80, 8'h7F, 1'b1, 0, "s80_7f");
    check("s80_7f.final_lgn", lgn_out, 1'b0);
    send_word(8'h80, 8'h7F, 1'b0, 0, "u80_7f");
    check("u80_7f.final_lgn", lgn_out, 1'b1);

    send_word(8'h5A, 8'h5A, 1'b0, 2, "eq_gaps");
    check("eq_gaps.final_e", e_out, 1'b1);
    gap();

    // Back-to-back words, no bubble.
    send_word(8'h10, 8'h20, 1'b0, 0, "b2b_1");
    send_word(8'hFF, 8'hFE, 1'b0, 0, "b2b_2");
    check("b2b_2.final_lgn", lgn_out, 1'b1);

    // Clear in the strobe cycle, then abort mid-word with a dropped digit.
    do_clear(1'b1);
    step(2'b00, 2'b00, 1'b0, "abort");
    step(2'b11, 2'b10, 1'b0, "abort");
    do_clear(1'b1);
    send_word(8'h30, 8'h20, 1'b0, 0, "post_abort");
    check("post_abort.final_lgn", lgn_out, 1'b1);

    for (int w = 0; w < 150; w++) begin
      logic [WW-1:0] wa, wb;
      logic          sm;
      wa = WW'($urandom);
      wb = ($urandom_range(0, 3) == 0) ? wa : WW'($urandom);
      sm = ($urandom_range(0, 1) != 0);
      for (int i = ND - 1; i >= 0; i--) begin
        if ($urandom_range(0, 29) == 0) do_clear($urandom_range(0, 1) != 0);
        step(wa[i*DW +: DW], wb[i*DW +: DW], (i == ND - 1) ? sm : ($urandom_range(0, 1) != 0), "rand");
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) gap();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
